uart_word_sequencer: RTL

Transmit-side controller for the UART-LED link. It accepts a 16-bit display word (four 4-bit digit codes, digit3 in [15:12] down to digit0 in [3:0]) and sequences the UART transmitter to send it as two bytes: high byte first, then low byte. This matches the byte-pair framing the receive side uses to rebuild its four digits. The block owns the transmitter's write strobe and enable, paces the bytes from the transmitter's busy flag, and reports completion or a stalled transmitter.

---
 rtl/uart_word_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/uart_word_sequencer.sv
// Sends a 16-bit display word to the UART transmitter as two bytes, high byte first,
// pacing each byte from Tx_BUSY and flagging a transmitter that never starts.
module uart_word_sequencer #(
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] word_in,
  input  logic        send,
  output logic        ready,
  output logic [7:0]  Tx_DATA,
  output logic        Tx_WR,
  output logic        Tx_EN,
  input  logic        Tx_BUSY,
  output logic        done,
  output logic        timeout_err
);

  localparam int CNT_MAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_HI_WR    = 4'd1;
  localparam logic [3:0] S_HI_START = 4'd2;
  localparam logic [3:0] S_HI_WAIT  = 4'd3;
  localparam logic [3:0] S_GAP      = 4'd4;
  localparam logic [3:0] S_LO_WR    = 4'd5;
  localparam logic [3:0] S_LO_START = 4'd6;
  localparam logic [3:0] S_LO_WAIT  = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;
  localparam logic [3:0] S_ABORT    = 4'd9;

  logic [3:0]       r_state;
  logic [3:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_word;
  logic [7:0]       r_tx_data;
  logic             r_timeout_err;
  logic             w_accept;

  assign w_accept = send && (r_state == S_IDLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (send) w_state_next = S_HI_WR;
      S_HI_WR:    w_state_next = S_HI_START;
      // Busy wins over the timeout on the last allowed START cycle.
      S_HI_START: begin
        if (Tx_BUSY)                  w_state_next = S_HI_WAIT;
        else if (r_cnt >= START_LAST) w_state_next = S_ABORT;
      end
      S_HI_WAIT:  if (!Tx_BUSY) w_state_next = (GAP_CYCLES == 0) ? S_LO_WR : S_GAP;
      S_GAP:      if (r_cnt >= GAP_LAST) w_state_next = S_LO_WR;
      S_LO_WR:    w_state_next = S_LO_START;
      S_LO_START: begin
        if (Tx_BUSY)                  w_state_next = S_LO_WAIT;
        else if (r_cnt >= START_LAST) w_state_next = S_ABORT;
      end
      S_LO_WAIT:  if (!Tx_BUSY) w_state_next = S_DONE;
      S_DONE:     w_state_next = S_IDLE;
      S_ABORT:    w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_word        <= 16'hFFFF;
      r_tx_data     <= 8'h00;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // Counter restarts on every state change and saturates rather than wrapping.
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_accept) begin
        r_word        <= word_in;
        r_tx_data     <= word_in[15:8];
        r_timeout_err <= 1'b0;
      end else if (w_state_next == S_LO_WR && r_state != S_LO_WR) begin
        r_tx_data <= r_word[7:0];
      end

      if (r_state == S_ABORT) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign Tx_WR       = (r_state == S_HI_WR) || (r_state == S_LO_WR);
  assign Tx_EN       = (r_state != S_IDLE) && (r_state != S_ABORT);
  assign done        = (r_state == S_DONE);
  assign Tx_DATA     = r_tx_data;
  assign timeout_err = r_timeout_err;

endmodule
